// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared types and constants for the 8-digit 7-segment driver
// Revision    : 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int CONV_STEPS = 16;

  typedef struct packed {
    logic       blank;
    logic [3:0] code;
  } digit_t;

  localparam digit_t BLANK = '{blank: 1'b1, code: 4'h0};

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g; entry 0 is rightmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/bin_to_bcd.sv
// ============================================================================
// bin_to_bcd : sequential 16-bit binary to 5-digit BCD (double dabble)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state;
  logic [3:0]  iter;
  logic [15:0] bin;
  logic [19:0] acc;
  logic [19:0] adj;

  always_comb begin
    adj = acc;
    for (int d = 0; d < 5; d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      iter  <= '0;
      bin   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bin   <= value;
            acc   <= '0;
            iter  <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Top bit of adj is always zero for a 16-bit input, so it is dropped.
          {acc, bin} <= {adj[18:0], bin, 1'b0};
          iter       <= iter + 4'd1;
          if (iter == 4'(CONV_STEPS - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign bcd  = acc;

endmodule

`default_nettype wire

// File: rtl/display_driver.sv
// ============================================================================
// display_driver : 8-digit multiplexed 7-segment driver, hex or decimal mode
// Revision       : 1.0
// ============================================================================
`default_nettype none

module display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        dec_mode,
  output logic        busy,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam int               SCAN_W   = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]            refresh_cnt;
  logic [SCAN_W-1:0]           scan_idx;
  digit_t [NUM_DIGITS-1:0]     digits;
  digit_t [NUM_DIGITS-1:0]     hex_digits;
  digit_t [NUM_DIGITS-1:0]     dec_digits;
  digit_t                      sel;
  logic                        accept;
  logic                        conv_done;
  logic [19:0]                 bcd;
  logic                        leading;
  logic [3:0]                  nib;

  assign accept = load & ~busy;

  bin_to_bcd u_bin_to_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept & dec_mode),
    .value (value),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_hex_map
    if (i < 4) begin : g_live
      assign hex_digits[i] = '{blank: 1'b0, code: value[4*i +: 4]};
    end else begin : g_unused
      assign hex_digits[i] = BLANK;
    end
  end

  // Leading-zero blanking scans from the most significant BCD digit down; digit 0 always shows.
  always_comb begin
    leading = 1'b1;
    nib     = 4'h0;
    for (int i = 5; i < NUM_DIGITS; i++) dec_digits[i] = BLANK;
    for (int i = 4; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (leading && (nib == 4'h0) && (i != 0)) begin
        dec_digits[i] = BLANK;
      end else begin
        dec_digits[i] = '{blank: 1'b0, code: nib};
        leading       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= BLANK;
    end else if (accept && !dec_mode) begin
      digits <= hex_digits;
    end else if (conv_done) begin
      digits <= dec_digits;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + SCAN_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  assign sel = digits[scan_idx];

  always_comb begin
    an  = '1;
    seg = 7'h7F;
    if (!sel.blank) begin
      an[scan_idx] = 1'b0;
      seg          = SEG_TABLE[sel.code];
    end
  end

  assign dp = 1'b1;

endmodule

`default_nettype wire
